// File: rtl/qubit_swap_engine_pkg.sv
// Shared types and constants for the sequential qubit SWAP engine.
// Provides the default fixed-point width, the LOAD/HOLD/RUN/UNLOAD state
// encodings reused by the sequential gate engines, and a selector check.
package qubit_swap_engine_pkg;

  // Signed fixed-point width of one real or imaginary part.
  localparam int unsigned TOTAL_WIDTH = 16;

  // Common state encoding for the sequential gate-engine skeleton.
  localparam logic [1:0] QSWAP_ST_LOAD   = 2'd0;
  localparam logic [1:0] QSWAP_ST_HOLD   = 2'd1;
  localparam logic [1:0] QSWAP_ST_RUN    = 2'd2;
  localparam logic [1:0] QSWAP_ST_UNLOAD = 2'd3;

  typedef enum logic [1:0] {
    ST_LOAD   = QSWAP_ST_LOAD,
    ST_HOLD   = QSWAP_ST_HOLD,
    ST_SWAP   = QSWAP_ST_RUN,
    ST_UNLOAD = QSWAP_ST_UNLOAD
  } state_e;

  // True when qubit selector q addresses one of n qubits.
  function automatic logic qsel_ok(input int unsigned q, input int unsigned n);
    return q < n;
  endfunction

endpackage

// File: rtl/qubit_swap_engine_if.sv
// Stream and control bundle of the qubit SWAP engine.
// Input stream : in_valid/in_ready/in_r/in_i (amplitudes in index order)
// Control      : start/qa/qb in, busy/err/done out
// Output stream: out_valid/out_ready/out_r/out_i/out_last
interface qubit_swap_engine_if
  import qubit_swap_engine_pkg::*;
#(
  parameter int unsigned DATA_W = TOTAL_WIDTH,
  parameter int unsigned QW     = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_r;
  logic signed [DATA_W-1:0] in_i;
  logic                     start;
  logic [QW-1:0]            qa;
  logic [QW-1:0]            qb;
  logic                     busy;
  logic                     err;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_r;
  logic signed [DATA_W-1:0] out_i;
  logic                     out_last;
  logic                     done;

  // Engine side.
  modport slave (
    input  in_valid, in_r, in_i, start, qa, qb, out_ready,
    output in_ready, busy, err, out_valid, out_r, out_i, out_last, done
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_r, in_i, start, qa, qb, out_ready,
    input  in_ready, busy, err, out_valid, out_r, out_i, out_last, done
  );
endinterface

// File: rtl/qubit_swap_engine_swap_index_map.sv
// swap_index_map: combinational partner-index generator for a qubit SWAP.
// Ports: i_k (current index), i_qa/i_qb (qubits to exchange),
//        o_j (i_k with bits qa and qb exchanged),
//        o_swap_en (bit qa of i_k is 1 and bit qb is 0, so each pair fires once).
module swap_index_map #(
  parameter int unsigned NUM_QUBITS = 3,
  parameter int unsigned QW         = 2
) (
  input  logic [NUM_QUBITS-1:0] i_k,
  input  logic [QW-1:0]         i_qa,
  input  logic [QW-1:0]         i_qb,
  output logic [NUM_QUBITS-1:0] o_j,
  output logic                  o_swap_en
);

  logic [NUM_QUBITS-1:0] w_mask_a;
  logic [NUM_QUBITS-1:0] w_mask_b;
  logic                  w_bit_a;
  logic                  w_bit_b;

  // One-hot masks; an out-of-range selector shifts to zero and is harmless.
  assign w_mask_a = NUM_QUBITS'(1) << i_qa;
  assign w_mask_b = NUM_QUBITS'(1) << i_qb;
  assign w_bit_a  = |(i_k & w_mask_a);
  assign w_bit_b  = |(i_k & w_mask_b);

  always_comb begin
    o_j       = i_k & ~(w_mask_a | w_mask_b);
    o_j       = o_j | (w_bit_b ? w_mask_a : '0) | (w_bit_a ? w_mask_b : '0);
    o_swap_en = w_bit_a & ~w_bit_b;
  end

endmodule

// File: rtl/qubit_swap_engine.sv
// qubit_swap_engine: sequential SWAP of two run-time-selected qubits on a
// 2^NUM_QUBITS complex fixed-point state vector.
// Ports: clk, rst (synchronous, active high), bus (slave modport):
//   input stream in_valid/in_ready/in_r/in_i, control start/qa/qb,
//   status busy/err/done, output stream out_valid/out_ready/out_r/out_i/out_last.
// Flow: LOAD DEPTH amplitudes -> HOLD for start -> SWAP DEPTH cycles
//       (skipped when qa == qb) -> UNLOAD DEPTH amplitudes -> LOAD.
module qubit_swap_engine
  import qubit_swap_engine_pkg::*;
#(
  parameter int unsigned NUM_QUBITS = 3,
  parameter int unsigned DATA_W     = TOTAL_WIDTH,
  parameter int unsigned QW         = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  qubit_swap_engine_if.slave bus
);

  localparam int unsigned DEPTH = 1 << NUM_QUBITS;
  localparam int unsigned CW    = NUM_QUBITS;

  state_e                   r_state, w_state_nxt;
  logic [CW-1:0]            r_cnt, w_cnt_nxt;
  logic [QW-1:0]            r_qa, r_qb, w_qa_nxt, w_qb_nxt;
  logic                     r_err, w_err_nxt;
  logic                     r_done, w_done_nxt;

  logic signed [DATA_W-1:0] r_amp_r [DEPTH];
  logic signed [DATA_W-1:0] r_amp_i [DEPTH];

  logic                     w_last;
  logic                     w_in_hs;
  logic                     w_out_hs;
  logic                     w_sel_ok;
  logic [CW-1:0]            w_j;
  logic                     w_swap_en;

  assign w_last   = (r_cnt == CW'(DEPTH - 1));
  assign w_in_hs  = bus.in_valid  && (r_state == ST_LOAD);
  assign w_out_hs = bus.out_ready && (r_state == ST_UNLOAD);
  assign w_sel_ok = qsel_ok(32'(bus.qa), NUM_QUBITS) && qsel_ok(32'(bus.qb), NUM_QUBITS);

  // Partner index for the current SWAP step.
  swap_index_map #(
    .NUM_QUBITS (NUM_QUBITS),
    .QW         (QW)
  ) u_map (
    .i_k       (r_cnt),
    .i_qa      (r_qa),
    .i_qb      (r_qb),
    .o_j       (w_j),
    .o_swap_en (w_swap_en)
  );

  // State, counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
      r_qa    <= '0;
      r_qb    <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_qa    <= w_qa_nxt;
      r_qb    <= w_qb_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_qa_nxt    = r_qa;
    w_qb_nxt    = r_qb;
    w_err_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        if (w_in_hs) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.start) begin
          if (!w_sel_ok) begin
            w_err_nxt = 1'b1;
          end else if (bus.qa == bus.qb) begin
            w_state_nxt = ST_UNLOAD;
          end else begin
            w_qa_nxt    = bus.qa;
            w_qb_nxt    = bus.qb;
            w_state_nxt = ST_SWAP;
          end
        end
      end
      ST_SWAP: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (w_out_hs) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Amplitude storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_in_hs) begin
        r_amp_r[r_cnt] <= bus.in_r;
        r_amp_i[r_cnt] <= bus.in_i;
      end
      if ((r_state == ST_SWAP) && w_swap_en) begin
        r_amp_r[r_cnt] <= r_amp_r[w_j];
        r_amp_i[r_cnt] <= r_amp_i[w_j];
        r_amp_r[w_j]   <= r_amp_r[r_cnt];
        r_amp_i[w_j]   <= r_amp_i[r_cnt];
      end
    end
  end

  // Outputs decode registered state; rst forces them to their idle values.
  assign bus.in_ready  = !rst && (r_state == ST_LOAD);
  assign bus.busy      = !rst && ((r_state == ST_SWAP) || (r_state == ST_UNLOAD));
  assign bus.out_valid = !rst && (r_state == ST_UNLOAD);
  assign bus.out_last  = bus.out_valid && w_last;
  assign bus.out_r     = bus.out_valid ? r_amp_r[r_cnt] : '0;
  assign bus.out_i     = bus.out_valid ? r_amp_i[r_cnt] : '0;
  assign bus.err       = !rst && r_err;
  assign bus.done      = !rst && r_done;

endmodule

// File: tb/tb_qubit_swap_engine.sv
// Directed bench for qubit_swap_engine: a 3-qubit and a 4-qubit instance
// share one clock; sel chooses which instance the stimulus addresses.
module tb_qubit_swap_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic               sel = 1'b0;
  logic               d_valid = 1'b0;
  logic signed [15:0] d_r = '0;
  logic signed [15:0] d_i = '0;
  logic               d_start = 1'b0;
  logic [1:0]         d_qa = '0;
  logic [1:0]         d_qb = '0;
  logic               d_ready = 1'b0;

  qubit_swap_engine_if #(.DATA_W(16), .QW(2)) ia ();
  qubit_swap_engine_if #(.DATA_W(16), .QW(2)) ib ();

  qubit_swap_engine #(.NUM_QUBITS(3), .DATA_W(16), .QW(2)) u_a (.clk(clk), .rst(rst), .bus(ia));
  qubit_swap_engine #(.NUM_QUBITS(4), .DATA_W(16), .QW(2)) u_b (.clk(clk), .rst(rst), .bus(ib));

  assign ia.in_valid  = !sel && d_valid;
  assign ib.in_valid  =  sel && d_valid;
  assign ia.in_r      = d_r;
  assign ib.in_r      = d_r;
  assign ia.in_i      = d_i;
  assign ib.in_i      = d_i;
  assign ia.start     = !sel && d_start;
  assign ib.start     =  sel && d_start;
  assign ia.qa        = d_qa;
  assign ib.qa        = d_qa;
  assign ia.qb        = d_qb;
  assign ib.qb        = d_qb;
  assign ia.out_ready = !sel && d_ready;
  assign ib.out_ready =  sel && d_ready;

  wire               o_in_ready  = sel ? ib.in_ready  : ia.in_ready;
  wire               o_busy      = sel ? ib.busy      : ia.busy;
  wire               o_err       = sel ? ib.err       : ia.err;
  wire               o_done      = sel ? ib.done      : ia.done;
  wire               o_valid     = sel ? ib.out_valid : ia.out_valid;
  wire               o_last      = sel ? ib.out_last  : ia.out_last;
  wire signed [15:0] o_r         = sel ? ib.out_r     : ia.out_r;
  wire signed [15:0] o_i         = sel ? ib.out_i     : ia.out_i;

  // Hand-computed output orders (entries past the depth unused).
  int e_q02 [16] = '{0, 4, 2, 6, 1, 5, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_id  [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_q01 [16] = '{0, 2, 1, 3, 4, 6, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_q30 [16] = '{0, 8, 2, 10, 4, 12, 6, 14, 1, 9, 3, 11, 5, 13, 7, 15};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int depth, input int off);
    for (int n = 0; n < depth; n++) begin
      d_valid = 1'b1;
      d_r     = 16'(n + off);
      d_i     = 16'(-(n + off));
      step();
    end
    d_valid = 1'b0;
    chk("hold_in_ready", 16'(o_in_ready), 16'd0);
    chk("hold_busy", 16'(o_busy), 16'd0);
  endtask

  task automatic start(input logic [1:0] qa, input logic [1:0] qb);
    d_start = 1'b1;
    d_qa    = qa;
    d_qb    = qb;
    step();
    d_start = 1'b0;
  endtask

  // Called at t+1 after an accepted non-identity start.
  task automatic swap_wait(input int depth);
    for (int i = 0; i < depth; i++) begin
      chk("swap_busy", 16'(o_busy), 16'd1);
      chk("swap_no_valid", 16'(o_valid), 16'd0);
      step();
    end
    chk("first_valid", 16'(o_valid), 16'd1);
  endtask

  task automatic unload(input int depth, input int e [16], input int off, input logic stall);
    logic [3:0]         pat = 4'b1001;
    int                 idx = 0;
    int                 cyc = 0;
    logic               held = 1'b0;
    logic signed [15:0] held_r = '0;
    logic               held_last = 1'b0;
    while (idx < depth && cyc < 200) begin
      d_ready = stall ? pat[2'(cyc)] : 1'b1;
      if (held) begin
        chk("stall_r", 16'(o_r), 16'(held_r));
        chk("stall_last", 16'(o_last), 16'(held_last));
      end
      if (o_valid) begin
        if (d_ready) begin
          chk("out_r", 16'(o_r), 16'(e[idx] + off));
          chk("out_i", 16'(o_i), 16'(-(e[idx] + off)));
          chk("out_last", 16'(o_last), 16'(idx == depth - 1));
          chk("no_early_done", 16'(o_done), 16'd0);
          idx++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_r    = o_r;
          held_last = o_last;
        end
      end
      step();
      cyc++;
    end
    d_ready = 1'b0;
    chk("beats", 16'(idx), 16'(depth));
    chk("done_pulse", 16'(o_done), 16'd1);
    chk("ready_with_done", 16'(o_in_ready), 16'd1);
    chk("valid_after", 16'(o_valid), 16'd0);
    step();
    chk("done_once", 16'(o_done), 16'd0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    step();
    chk("rst_in_ready", 16'(o_in_ready), 16'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(o_in_ready), 16'd1);
    chk("rst_out_valid", 16'(o_valid), 16'd0);
    chk("rst_out_last", 16'(o_last), 16'd0);
    chk("rst_busy", 16'(o_busy), 16'd0);
    chk("rst_err", 16'(o_err), 16'd0);
    chk("rst_done", 16'(o_done), 16'd0);
    chk("rst_out_r", 16'(o_r), 16'd0);
    chk("rst_out_i", 16'(o_i), 16'd0);

    // q0 <-> q2 on 3 qubits, with start offered during load (ignored).
    d_start = 1'b1;
    load(8, 0);
    d_start = 1'b0;
    chk("no_err_in_load", 16'(o_err), 16'd0);
    start(2'd0, 2'd2);
    swap_wait(8);
    unload(8, e_q02, 0, 1'b0);

    // Identity: first out_valid at t+1.
    load(8, 0);
    start(2'd1, 2'd1);
    chk("identity_valid", 16'(o_valid), 16'd1);
    chk("identity_busy", 16'(o_busy), 16'd1);
    unload(8, e_id, 0, 1'b0);

    // Out-of-range selector, then q0 <-> q1 with backpressure.
    load(8, 0);
    start(2'd3, 2'd0);
    chk("err_pulse", 16'(o_err), 16'd1);
    chk("err_stays_hold", 16'(o_in_ready | o_busy | o_valid), 16'd0);
    step();
    chk("err_one_cycle", 16'(o_err), 16'd0);
    chk("still_hold", 16'(o_busy), 16'd0);
    start(2'd0, 2'd1);
    d_valid = 1'b1;
    d_r     = 16'sh7fff;
    d_i     = 16'sh7fff;
    swap_wait(8);
    d_valid = 1'b0;
    unload(8, e_q01, 0, 1'b1);

    // Reset at SWAP k=3, then a fresh load with different data.
    load(8, 0);
    start(2'd0, 2'd2);
    step();
    step();
    step();
    chk("mid_swap_busy", 16'(o_busy), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 16'(o_in_ready), 16'd1);
    chk("mid_rst_busy", 16'(o_busy), 16'd0);
    chk("mid_rst_err", 16'(o_err), 16'd0);
    chk("mid_rst_done", 16'(o_done), 16'd0);
    load(8, 20);
    start(2'd0, 2'd2);
    swap_wait(8);
    unload(8, e_q02, 20, 1'b0);

    // 4 qubits, q3 <-> q0: 16-cycle SWAP.
    sel = 1'b1;
    #1;
    chk("b_in_ready", 16'(o_in_ready), 16'd1);
    load(16, 100);
    start(2'd3, 2'd0);
    swap_wait(16);
    unload(16, e_q30, 100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
